// File: rtl/vdp_sprite_meta_pkg.sv
// Shared types for the sprite metadata writer: block codes, host address fields, drain FSM states.
package vdp_sprite_meta_pkg;

    typedef enum logic [1:0] {
        BLK_X    = 2'd0,
        BLK_Y    = 2'd1,
        BLK_G    = 2'd2,
        BLK_RSVD = 2'd3
    } blk_e;

    localparam int ADDR_BLK_MSB = 6;
    localparam int ADDR_BLK_LSB = 5;
    localparam int ADDR_IDX_MSB = 4;
    localparam int ADDR_IDX_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    typedef struct packed {
        blk_e        blk;
        logic [4:0]  idx;
        logic [15:0] data;
    } meta_entry_t;

    function automatic logic [2:0] blk_onehot(input blk_e blk);
        case (blk)
            BLK_X:   blk_onehot = 3'b001;
            BLK_Y:   blk_onehot = 3'b010;
            BLK_G:   blk_onehot = 3'b100;
            default: blk_onehot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/vdp_meta_fifo.sv
// Synchronous write queue with async active-low reset, single-cycle flush and occupancy output.
module vdp_meta_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 23,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [LW-1:0]    level_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign empty_o   = (level_q == '0);
    assign full_o    = (level_q == LW'(DEPTH));
    assign do_push   = push_i && !full_o && !flush_i;
    assign do_pop    = pop_i && !empty_o && !flush_i;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/vdp_sprite_meta_writer.sv
// Queues host sprite-attribute writes and drains them into the sprite RAMs during the commit window.
// Define VDP_SPRITE_META_BYPASS_EN to let a write into an empty queue go straight to the outputs.
//
// state    | meaning
// ST_IDLE  | waiting for commit_window with queued entries
// ST_DRAIN | popping one entry per cycle while the window is open
// ST_FLUSH | one-cycle discard of all queued writes
module vdp_sprite_meta_writer
    import vdp_sprite_meta_pkg::*;
#(
    parameter int SPRITES_TOTAL = 31,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        host_valid,
    output logic                        host_ready,
    input  logic [6:0]                  host_address,
    input  logic [15:0]                 host_write_data,
    input  logic                        commit_window,
    input  logic                        flush,
    input  logic                        clear_error,
    output logic [4:0]                  meta_address,
    output logic [15:0]                 meta_write_data,
    output logic [2:0]                  meta_block_select,
    output logic                        meta_we,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        addr_error
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    state_e      state_q, state_d;
    meta_entry_t req_entry, rd_entry;
    logic        req_bad, handshake, push, pop, bypass;
    logic        fifo_empty, fifo_full;
    logic [LW-1:0] level;

    logic        meta_we_q;
    logic [4:0]  meta_addr_q;
    logic [15:0] meta_data_q;
    logic [2:0]  meta_sel_q;
    logic        addr_error_q;

    assign req_entry.blk  = blk_e'(host_address[ADDR_BLK_MSB:ADDR_BLK_LSB]);
    assign req_entry.idx  = host_address[ADDR_IDX_MSB:ADDR_IDX_LSB];
    assign req_entry.data = host_write_data;

    assign req_bad   = (req_entry.blk == BLK_RSVD) || (32'(req_entry.idx) >= SPRITES_TOTAL);
    // Gating with reset_n keeps ready low for the whole reset, not just until the next edge.
    assign host_ready = reset_n && !fifo_full && !flush;
    assign handshake  = host_valid && host_ready;

    assign pop = (state_q != ST_FLUSH) && commit_window && !fifo_empty && !flush;

`ifdef VDP_SPRITE_META_BYPASS_EN
    assign bypass = handshake && !req_bad && fifo_empty && commit_window && !flush;
`else
    assign bypass = 1'b0;
`endif
    assign push = handshake && !req_bad && !bypass;

    vdp_meta_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(meta_entry_t))
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_i    (push),
        .pop_i     (pop),
        .flush_i   (flush),
        .wr_data_i (req_entry),
        .rd_data_o (rd_entry),
        .level_o   (level),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (commit_window && !fifo_empty) state_d = ST_DRAIN;
            ST_DRAIN: if (!commit_window || fifo_empty) state_d = ST_IDLE;
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_FLUSH;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_we_q   <= 1'b0;
            meta_addr_q <= '0;
            meta_data_q <= '0;
            meta_sel_q  <= '0;
        end else begin
            meta_we_q <= pop || bypass;
            if (pop) begin
                meta_addr_q <= rd_entry.idx;
                meta_data_q <= rd_entry.data;
                meta_sel_q  <= blk_onehot(rd_entry.blk);
            end else if (bypass) begin
                meta_addr_q <= req_entry.idx;
                meta_data_q <= req_entry.data;
                meta_sel_q  <= blk_onehot(req_entry.blk);
            end
        end
    end

    // A clear in the same cycle as a dropped request wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_error_q <= 1'b0;
        end else if (clear_error) begin
            addr_error_q <= 1'b0;
        end else if (handshake && req_bad) begin
            addr_error_q <= 1'b1;
        end
    end

    assign meta_we           = meta_we_q;
    assign meta_address      = meta_addr_q;
    assign meta_write_data   = meta_data_q;
    assign meta_block_select = meta_sel_q;
    assign fifo_level        = level;
    assign addr_error        = addr_error_q;

endmodule

// File: tb/tb_vdp_sprite_meta_writer.sv
// Scoreboard bench for vdp_sprite_meta_writer: expected meta writes queued at handshake, checked on meta_we.
module tb_vdp_sprite_meta_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        host_valid;
    logic        host_ready;
    logic [6:0]  host_address;
    logic [15:0] host_write_data;
    logic        commit_window;
    logic        flush;
    logic        clear_error;
    logic [4:0]  meta_address;
    logic [15:0] meta_write_data;
    logic [2:0]  meta_block_select;
    logic        meta_we;
    logic [2:0]  fifo_level;
    logic        addr_error;

`ifdef VDP_SPRITE_META_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    int n_vec = 0;
    int n_miscmp = 0;
    int cyc = 0;
    logic [23:0] sb[$];
    int we_log[$];

    vdp_sprite_meta_writer dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .host_valid        (host_valid),
        .host_ready        (host_ready),
        .host_address      (host_address),
        .host_write_data   (host_write_data),
        .commit_window     (commit_window),
        .flush             (flush),
        .clear_error       (clear_error),
        .meta_address      (meta_address),
        .meta_write_data   (meta_write_data),
        .meta_block_select (meta_block_select),
        .meta_we           (meta_we),
        .fifo_level        (fifo_level),
        .addr_error        (addr_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] exp_ent(input logic [1:0] blk, input logic [4:0] idx,
                                            input logic [15:0] d);
        logic [2:0] sel;
        case (blk)
            2'd0:    sel = 3'b001;
            2'd1:    sel = 3'b010;
            default: sel = 3'b100;
        endcase
        return {sel, idx, d};
    endfunction

    always @(negedge clk) begin
        if (meta_we === 1'b1) begin
            we_log.push_back(cyc);
            if (sb.size() == 0) chk_eq("unexpected_we", 32'(meta_we), 32'd0);
            else chk_eq("meta_out", {8'd0, meta_block_select, meta_address, meta_write_data},
                        {8'd0, sb.pop_front()});
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds the request until a handshake edge; hs_cyc is the edge count after that edge.
    task automatic host_write(input logic [1:0] blk, input logic [4:0] idx, input logic [15:0] d,
                              input bit exp_out, output int hs_cyc);
        bit done;
        done = 1'b0;
        host_valid = 1'b1;
        host_address = {blk, idx};
        host_write_data = d;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = host_ready;
            @(posedge clk);
            #1;
        end
        host_valid = 1'b0;
        hs_cyc = cyc;
        chk_eq("handshake", 32'(done), 32'd1);
        if (exp_out) sb.push_back(exp_ent(blk, idx, d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        reset_n = 1'b0;
        host_valid = 1'b0;
        host_address = '0;
        host_write_data = '0;
        commit_window = 1'b0;
        flush = 1'b0;
        clear_error = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk_eq("rst_ready", 32'(host_ready), 0);
        chk_eq("rst_we", 32'(meta_we), 0);
        chk_eq("rst_level", 32'(fifo_level), 0);
        chk_eq("rst_err", 32'(addr_error), 0);
        chk_eq("rst_addr", 32'(meta_address), 0);
        chk_eq("rst_data", 32'(meta_write_data), 0);
        chk_eq("rst_sel", 32'(meta_block_select), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        #1 chk_eq("ready_after_rst", 32'(host_ready), 1);
        tick();

        // Two queued writes drained back-to-back when the window opens
        we_log.delete();
        host_write(2'd1, 5'd3, 16'h1234, 1'b1, hs);
        host_write(2'd2, 5'd30, 16'hBEEF, 1'b1, hs);
        chk_eq("lvl_two", 32'(fifo_level), 2);
        tick(4);
        chk_eq("no_we_closed", we_log.size(), 0);
        commit_window = 1'b1;
        hs = cyc;
        tick(4);
        chk_eq("drain_cnt", we_log.size(), 2);
        if (we_log.size() == 2) begin
            chk_eq("drain_first", we_log[0], hs + 1);
            chk_eq("drain_consec", we_log[1] - we_log[0], 1);
        end
        chk_eq("drain_lvl", 32'(fifo_level), 0);
        chk_eq("hold_addr", 32'(meta_address), 30);
        chk_eq("hold_data", 32'(meta_write_data), 32'hBEEF);
        commit_window = 1'b0;
        tick();

        // Full queue back-pressure; fifth request waits for the first pop
        we_log.delete();
        for (int i = 0; i < 4; i++)
            host_write(2'(i % 3), 5'(i + 10), 16'(16'hA000 + i), 1'b1, hs);
        chk_eq("full_level", 32'(fifo_level), 4);
        chk_eq("full_ready", 32'(host_ready), 0);
        host_valid = 1'b1;
        host_address = {2'd0, 5'd20};
        host_write_data = 16'hC0DE;
        tick(3);
        chk_eq("held_level", 32'(fifo_level), 4);
        sb.push_back(exp_ent(2'd0, 5'd20, 16'hC0DE));
        commit_window = 1'b1;
        tick();
        chk_eq("pop_no_push_lvl", 32'(fifo_level), 3);
        chk_eq("ready_after_pop", 32'(host_ready), 1);
        tick();
        host_valid = 1'b0;
        chk_eq("push_pop_lvl", 32'(fifo_level), 3);
        tick(6);
        commit_window = 1'b0;
        chk_eq("wrap_drain_cnt", we_log.size(), 5);
        chk_eq("wrap_drain_lvl", 32'(fifo_level), 0);

        // Dropped requests and sticky error
        we_log.delete();
        commit_window = 1'b1;
        host_write(2'd3, 5'd0, 16'h1111, 1'b0, hs);
        host_write(2'd0, 5'd31, 16'h2222, 1'b0, hs);
        tick(3);
        chk_eq("err_set", 32'(addr_error), 1);
        chk_eq("err_lvl", 32'(fifo_level), 0);
        chk_eq("err_no_we", we_log.size(), 0);
        host_valid = 1'b1;
        host_address = {2'd3, 5'd5};
        clear_error = 1'b1;
        tick();
        host_valid = 1'b0;
        clear_error = 1'b0;
        chk_eq("clr_priority", 32'(addr_error), 0);
        host_write(2'd0, 5'd31, 16'h3333, 1'b0, hs);
        tick();
        chk_eq("err_reset", 32'(addr_error), 1);
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        chk_eq("err_clear", 32'(addr_error), 0);
        commit_window = 1'b0;
        tick();

        // Flush with a concurrent host write
        we_log.delete();
        for (int i = 0; i < 3; i++)
            host_write(2'd1, 5'(i), 16'(16'h5000 + i), 1'b0, hs);
        commit_window = 1'b1;
        flush = 1'b1;
        host_valid = 1'b1;
        host_address = {2'd0, 5'd9};
        host_write_data = 16'h9999;
        #1 chk_eq("flush_ready", 32'(host_ready), 0);
        tick();
        flush = 1'b0;
        host_valid = 1'b0;
        chk_eq("flush_lvl", 32'(fifo_level), 0);
        tick(5);
        chk_eq("flush_no_we", we_log.size(), 0);
        chk_eq("flush_lvl_late", 32'(fifo_level), 0);
        commit_window = 1'b0;
        tick();

        // Reset mid-drain
        we_log.delete();
        for (int i = 0; i < 4; i++)
            host_write(2'd2, 5'(i + 4), 16'(16'h6000 + i), 1'b1, hs);
        commit_window = 1'b1;
        tick(2);
        chk_eq("middrain_lvl", 32'(fifo_level), 2);
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk_eq("rst_mid_we", 32'(meta_we), 0);
        chk_eq("rst_mid_lvl", 32'(fifo_level), 0);
        chk_eq("rst_mid_ready", 32'(host_ready), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        #1 chk_eq("rst_mid_ready_rel", 32'(host_ready), 1);
        tick(4);
        chk_eq("rst_mid_we_cnt", we_log.size(), 1);
        chk_eq("rst_mid_lvl_rel", 32'(fifo_level), 0);
        commit_window = 1'b0;
        tick();

        // Single write into an empty queue with the window open
        we_log.delete();
        commit_window = 1'b1;
        host_write(2'd0, 5'd7, 16'h5A5A, 1'b1, hs);
        tick(4);
        chk_eq("lat_cnt", we_log.size(), 1);
        if (we_log.size() == 1) chk_eq("lat_cycle", we_log[0] - hs, LAT);
        commit_window = 1'b0;
        chk_eq("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
